// File: rtl/ad5791_pkg.sv
// AD5791 serializer shared definitions.
// Frame layout, register addresses and FSM state encoding.
package ad5791_pkg;

    localparam int FRAME_BITS = 24;
    localparam int DATA_BITS  = 20;

    localparam logic [2:0] ADDR_DAC  = 3'b001;
    localparam logic [2:0] ADDR_CTRL = 3'b010;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    function automatic logic [FRAME_BITS-1:0] mk_frame(
        input logic [2:0]           addr,
        input logic [DATA_BITS-1:0] data
    );
        return {1'b0, addr, data};
    endfunction

endpackage

// File: rtl/ad5791_sclk_gen.sv
// AD5791 SCLK divider.
// Idles high; toggles every CLK_DIV cycles while enabled, with edge strobes.
module ad5791_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic a_clk,
    input  logic reset,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;
    logic       r_sclk;
    logic       w_tick;

    assign w_tick = i_en && (r_cnt == DIV_M1);
    assign o_rise = w_tick && !r_sclk;
    assign o_fall = w_tick && r_sclk;
    assign o_sclk = r_sclk;

    // Half-period counter; disabling re-arms a full high phase
    always_ff @(posedge a_clk) begin
        if (reset || !i_en) begin
            r_cnt  <= 8'd0;
            r_sclk <= 1'b1;
        end else if (w_tick) begin
            r_cnt  <= 8'd0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/ad5791_serializer.sv
// AD5791 multi-channel SPI serializer.
// Shared SCLK/SYNC, one SDIN lane per DAC, control frame after reset.
module ad5791_serializer
    import ad5791_pkg::*;
#(
    parameter int NUM_DAC  = 4,
    parameter int CLK_DIV  = 2,
    parameter int SYNC_GAP = 4
) (
    input  logic                         a_clk,
    input  logic                         reset,
    input  logic [NUM_DAC*DATA_BITS-1:0] s_dac_data,
    input  logic                         s_dac_valid,
    output logic                         s_dac_ready,
    input  logic [DATA_BITS-1:0]         cfg_word,
    input  logic                         cfg_req,
    output logic                         PMD_clk,
    output logic                         PMD_sync,
    output logic [NUM_DAC-1:0]           PMD_dac,
    output logic                         busy,
    output logic [31:0]                  frame_count
);

    // GAP lasts SYNC_GAP-1 cycles; the IDLE cycle supplies the last high cycle
    localparam logic [7:0] GAP_LOAD = (SYNC_GAP > 1) ? 8'(SYNC_GAP - 2) : 8'd0;

    state_t                r_state;
    state_t                w_state_next;
    logic [FRAME_BITS-1:0] r_sr [NUM_DAC];
    logic                  r_sync;
    logic                  r_is_dac;
    logic                  r_cfg_pend;
    logic [4:0]            r_nfall;
    logic [7:0]            r_gap;
    logic [31:0]           r_frame_count;

    logic w_load;
    logic w_load_cfg;
    logic w_cfg_take;
    logic w_frame_end;
    logic w_sclk;
    logic w_rise;
    logic w_fall;
    logic w_shift_en;

    assign w_shift_en = (r_state == ST_SHIFT);

    ad5791_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk (
        .a_clk  (a_clk),
        .reset  (reset),
        .i_en   (w_shift_en),
        .o_sclk (w_sclk),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // State register
    always_ff @(posedge a_clk) begin
        if (reset) r_state <= ST_INIT;
        else       r_state <= w_state_next;
    end

    // Next state and frame load/end strobes
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_cfg   = 1'b0;
        w_cfg_take   = 1'b0;
        w_frame_end  = 1'b0;
        unique case (r_state)
            ST_INIT: begin
                w_load       = 1'b1;
                w_load_cfg   = 1'b1;
                w_state_next = ST_SHIFT;
            end
            ST_IDLE: begin
                if (r_cfg_pend) begin
                    w_load       = 1'b1;
                    w_load_cfg   = 1'b1;
                    w_cfg_take   = 1'b1;
                    w_state_next = ST_SHIFT;
                end else if (s_dac_valid) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_rise && (r_nfall == 5'(FRAME_BITS))) begin
                    w_frame_end  = 1'b1;
                    w_state_next = (SYNC_GAP > 1) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gap == 8'd0) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    // Sticky control-write request; repeated pulses collapse into one
    always_ff @(posedge a_clk) begin
        if (reset) r_cfg_pend <= 1'b0;
        else       r_cfg_pend <= cfg_req | (r_cfg_pend & ~w_cfg_take);
    end

    // Lane shift registers, SYNC and falling-edge count
    always_ff @(posedge a_clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_DAC; k++) r_sr[k] <= '0;
            r_sync   <= 1'b1;
            r_nfall  <= 5'd0;
            r_is_dac <= 1'b0;
        end else if (w_load) begin
            for (int k = 0; k < NUM_DAC; k++) begin
                r_sr[k] <= w_load_cfg ? mk_frame(ADDR_CTRL, cfg_word)
                         : mk_frame(ADDR_DAC, s_dac_data[k*DATA_BITS +: DATA_BITS]);
            end
            r_sync   <= 1'b0;
            r_nfall  <= 5'd0;
            r_is_dac <= ~w_load_cfg;
        end else begin
            if (w_rise) begin
                for (int k = 0; k < NUM_DAC; k++) r_sr[k] <= {r_sr[k][FRAME_BITS-2:0], 1'b0};
            end
            if (w_fall)      r_nfall <= r_nfall + 5'd1;
            if (w_frame_end) r_sync  <= 1'b1;
        end
    end

    // Inter-frame gap timer
    always_ff @(posedge a_clk) begin
        if (reset)                                    r_gap <= 8'd0;
        else if (w_frame_end)                         r_gap <= GAP_LOAD;
        else if (r_state == ST_GAP && r_gap != 8'd0)  r_gap <= r_gap - 8'd1;
    end

    // Completed DAC-register frames, counted as SYNC rises
    always_ff @(posedge a_clk) begin
        if (reset)                        r_frame_count <= 32'd0;
        else if (w_frame_end && r_is_dac) r_frame_count <= r_frame_count + 32'd1;
    end

    // Lane MSBs drive SDIN
    always_comb begin
        PMD_dac = '0;
        for (int k = 0; k < NUM_DAC; k++) PMD_dac[k] = r_sr[k][FRAME_BITS-1];
    end

    assign s_dac_ready = (r_state == ST_IDLE) && !r_cfg_pend;
    assign busy        = (r_state != ST_IDLE);
    assign PMD_clk     = w_sclk;
    assign PMD_sync    = r_sync;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_ad5791_serializer.sv
// Bench for ad5791_serializer: SPI frame monitor plus frame-level model.
// Directed sequence with randomized channel data.
module tb_ad5791_serializer;

    localparam int N  = 4;
    localparam int D  = 2;
    localparam int SG = 4;

    logic          a_clk = 1'b0;
    logic          reset;
    logic [N*20-1:0] s_dac_data;
    logic          s_dac_valid;
    logic          s_dac_ready;
    logic [19:0]   cfg_word;
    logic          cfg_req;
    logic          PMD_clk;
    logic          PMD_sync;
    logic [N-1:0]  PMD_dac;
    logic          busy;
    logic [31:0]   frame_count;

    ad5791_serializer #(.NUM_DAC(N), .CLK_DIV(D), .SYNC_GAP(SG)) dut (
        .a_clk       (a_clk),
        .reset       (reset),
        .s_dac_data  (s_dac_data),
        .s_dac_valid (s_dac_valid),
        .s_dac_ready (s_dac_ready),
        .cfg_word    (cfg_word),
        .cfg_req     (cfg_req),
        .PMD_clk     (PMD_clk),
        .PMD_sync    (PMD_sync),
        .PMD_dac     (PMD_dac),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 a_clk = ~a_clk;

    typedef struct packed {
        logic [N-1:0][23:0] lane;
        logic [31:0]        low;
        logic [31:0]        nfall;
        logic [31:0]        fc;
    } cap_t;

    typedef struct packed {
        logic               is_dac;
        logic [N-1:0][23:0] lane;
    } exp_t;

    cap_t        cap_q[$];
    exp_t        exp_q[$];
    int          gap_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] exp_fc   = 32'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: rebuild each lane's word from SDIN at SCLK falling edges
    logic               in_frame = 1'b0;
    logic               seen     = 1'b0;
    logic               prev_clk = 1'b1;
    logic [N-1:0]       prev_dac = '0;
    int                 low_cnt, nf_cnt, hi_cnt;
    logic [N-1:0][23:0] sh;
    always @(negedge a_clk) begin
        cap_t c;
        if (reset) begin
            in_frame = 1'b0;
            seen     = 1'b0;
            hi_cnt   = 0;
        end else if (!PMD_sync) begin
            if (!in_frame) begin
                if (seen) gap_q.push_back(hi_cnt);
                in_frame = 1'b1;
                low_cnt  = 0;
                nf_cnt   = 0;
                sh       = '0;
            end else begin
                if (prev_clk && !PMD_clk) begin
                    nf_cnt++;
                    for (int k = 0; k < N; k++) sh[k] = {sh[k][22:0], PMD_dac[k]};
                end
                if (PMD_dac !== prev_dac)
                    chk("dac_only_on_rise", {63'd0, !prev_clk && PMD_clk}, 64'd1);
            end
            low_cnt++;
        end else begin
            if (in_frame) begin
                c.lane  = sh;
                c.low   = low_cnt;
                c.nfall = nf_cnt;
                c.fc    = frame_count;
                cap_q.push_back(c);
                in_frame = 1'b0;
                seen     = 1'b1;
                hi_cnt   = 0;
            end
            hi_cnt++;
        end
        prev_clk = PMD_clk;
        prev_dac = PMD_dac;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk_exp(input logic is_dac, input logic [N*20-1:0] d);
        exp_t e;
        e.is_dac = is_dac;
        for (int k = 0; k < N; k++)
            e.lane[k] = {1'b0, (is_dac ? 3'b001 : 3'b010), (is_dac ? d[k*20 +: 20] : d[19:0])};
        return e;
    endfunction

    function automatic logic [N*20-1:0] rnd_data();
        logic [N*20-1:0] d;
        for (int k = 0; k < N; k++) d[k*20 +: 20] = 20'($urandom);
        return d;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge a_clk);
        #1;
    endtask

    // Offer noise while not ready; present the real word once ready is seen
    task automatic do_xfer(input logic [N*20-1:0] d, input bit keep_valid);
        bit ok = 0;
        s_dac_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge a_clk);
            if (s_dac_ready) begin
                ok = 1;
                break;
            end
            s_dac_data = rnd_data();
        end
        chk("xfer_ready_seen", {63'd0, ok}, 64'd1);
        s_dac_data = d;
        exp_q.push_back(mk_exp(1'b1, d));
        @(posedge a_clk);
        #1;
        s_dac_valid = keep_valid;
        s_dac_data  = rnd_data();
    endtask

    task automatic check_frame(input string tag);
        cap_t c;
        exp_t e;
        bit   ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (cap_q.size() > 0) begin
                ok = 1;
                break;
            end
            @(negedge a_clk);
        end
        chk({tag, "_arrived"}, {63'd0, ok}, 64'd1);
        if (ok && exp_q.size() > 0) begin
            c = cap_q.pop_front();
            e = exp_q.pop_front();
            if (e.is_dac) exp_fc = exp_fc + 32'd1;
            for (int k = 0; k < N; k++)
                chk($sformatf("%s_lane%0d", tag, k), {40'd0, c.lane[k]}, {40'd0, e.lane[k]});
            chk({tag, "_sync_low"}, {32'd0, c.low}, 64'd48 * D);
            chk({tag, "_falls"}, {32'd0, c.nfall}, 64'd24);
            chk({tag, "_frame_count"}, {32'd0, c.fc}, {32'd0, exp_fc});
        end
    endtask

    initial begin
        logic [N*20-1:0] d;
        reset       = 1'b1;
        s_dac_data  = '0;
        s_dac_valid = 1'b0;
        cfg_word    = 20'h00012;
        cfg_req     = 1'b0;
        step(3);
        chk("rst_sync", {63'd0, PMD_sync}, 64'd1);
        chk("rst_clk", {63'd0, PMD_clk}, 64'd1);
        chk("rst_dac", {60'd0, PMD_dac}, 64'd0);
        chk("rst_ready", {63'd0, s_dac_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd1);
        chk("rst_fc", {32'd0, frame_count}, 64'd0);

        exp_q.push_back(mk_exp(1'b0, {60'd0, 20'h00012}));
        reset = 1'b0;
        step(2);
        cfg_word = 20'($urandom);
        check_frame("init");
        step(SG);
        chk("init_ready", {63'd0, s_dac_ready}, 64'd1);
        chk("init_busy", {63'd0, busy}, 64'd0);

        d = {20'h12345, 20'h80000, 20'h00000, 20'hFFFFF};
        do_xfer(d, 1'b0);
        check_frame("dir");

        for (int n = 0; n < 6; n++) begin
            do_xfer(rnd_data(), 1'b0);
            check_frame($sformatf("rnd%0d", n));
            step($urandom_range(0, 8));
        end

        step(10);
        gap_q.delete();
        for (int n = 0; n < 5; n++) do_xfer(rnd_data(), 1'b1);
        s_dac_valid = 1'b0;
        for (int n = 0; n < 5; n++) check_frame($sformatf("stream%0d", n));
        chk("stream_gaps", {32'd0, 32'(gap_q.size())}, 64'd5);
        for (int n = 1; n < gap_q.size(); n++)
            chk($sformatf("stream_gap%0d", n), {32'd0, 32'(gap_q[n])}, SG);

        step(10);
        cfg_word = 20'($urandom);
        do_xfer(rnd_data(), 1'b1);
        step(20);
        cfg_req = 1'b1;
        step(1);
        cfg_req = 1'b0;
        step(10);
        cfg_req = 1'b1;
        step(1);
        cfg_req = 1'b0;
        exp_q.push_back(mk_exp(1'b0, {60'd0, cfg_word}));
        do_xfer(rnd_data(), 1'b0);
        check_frame("cfgA");
        check_frame("cfgCtrl");
        check_frame("cfgB");
        step(300);
        chk("cfg_no_extra", {32'd0, 32'(cap_q.size())}, 64'd0);

        do_xfer(rnd_data(), 1'b0);
        step(29);
        reset = 1'b1;
        step(1);
        chk("midrst_sync", {63'd0, PMD_sync}, 64'd1);
        chk("midrst_clk", {63'd0, PMD_clk}, 64'd1);
        chk("midrst_busy", {63'd0, busy}, 64'd1);
        exp_q.delete();
        exp_fc   = 32'd0;
        cfg_word = 20'($urandom);
        exp_q.push_back(mk_exp(1'b0, {60'd0, cfg_word}));
        step(2);
        chk("midrst_no_partial", {32'd0, 32'(cap_q.size())}, 64'd0);
        chk("midrst_fc", {32'd0, frame_count}, 64'd0);
        reset = 1'b0;
        check_frame("reinit");

        step(10);
        force dut.r_frame_count = 32'hFFFFFFFF;
        step(1);
        release dut.r_frame_count;
        step(1);
        chk("force_held", {32'd0, frame_count}, 64'hFFFFFFFF);
        exp_fc = 32'hFFFFFFFF;
        do_xfer(rnd_data(), 1'b0);
        check_frame("wrap");
        step(5);
        chk("wrap_fc", {32'd0, frame_count}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
